// File: rtl/nibble_pkg.sv
// Shared encodings for the nibble controller: opcodes, ALU ops, FSM states, field widths.
// Pure constants/functions; no latency, no backpressure.
package nibble_pkg;

    localparam int INSTR_W = 24;
    localparam int OP_W    = 3;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 8;

    localparam logic [OP_W-1:0] OP_LDI  = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_W-1:0] OP_AND  = 3'd3;
    localparam logic [OP_W-1:0] OP_OR   = 3'd4;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd5;
    localparam logic [OP_W-1:0] OP_BRZ  = 3'd6;
    localparam logic [OP_W-1:0] OP_HALT = 3'd7;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    localparam logic [1:0] PCSEL_HOLD = 2'd0;
    localparam logic [1:0] PCSEL_INC  = 2'd1;
    localparam logic [1:0] PCSEL_TGT  = 2'd2;
    localparam logic [1:0] PCSEL_RST  = 2'd3;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic [1:0] alu_of_op(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/nibble_ctrl_fsm_if.sv
// Instruction-memory fetch bus: req held until a one-cycle ack strobe carries the word.
// No latency of its own; the memory stalls the controller simply by withholding ack.
interface nibble_ctrl_fsm_if #(
    parameter int PC_W = 8
);
    import nibble_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface

// File: rtl/nibble_pc_next.sv
// Combinational next-PC select: hold, increment (wrapping), jump target, or reset vector.
// Zero latency; no backpressure.
module nibble_pc_next
    import nibble_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic [1:0]       sel,
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] target,
    output logic [PC_W-1:0]  pc_nxt
);

    logic [PC_W-1:0] tgt;

    // Narrow PCs drop the upper target bits, wide PCs zero-extend it.
    always_comb begin
        tgt = '0;
        for (int i = 0; i < PC_W; i++) begin
            if (i < IMM_W) tgt[i] = target[i];
        end
    end

    always_comb begin
        pc_nxt = pc;
        case (sel)
            PCSEL_INC: pc_nxt = pc + PC_W'(1);
            PCSEL_TGT: pc_nxt = tgt;
            PCSEL_RST: pc_nxt = RESET_PC;
            default:   pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/nibble_ctrl_fsm.sv
// Fetch/decode/execute controller, one instruction in flight; NIBBLE_RETIRE_CNT_EN adds retired_cnt.
// 3 cycles per instruction with zero-wait memory; stalls in FETCH until imem_ack.
module nibble_ctrl_fsm
    import nibble_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    nibble_ctrl_fsm_if.master   imem,
    output logic [INSTR_W-1:0]  ir,
    input  logic [OP_W-1:0]     dec_op_code,
    input  logic [IMM_W-1:0]    dec_y,
    input  logic                alu_zero,
    output logic [1:0]          alu_op,
    output logic                alu_src_imm,
    output logic                rf_we,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted
`ifdef NIBBLE_RETIRE_CNT_EN
    ,
    output logic [31:0]         retired_cnt
`endif
);

    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [1:0]      pc_sel;
    logic [PC_W-1:0] pc_nxt;
    logic            zflag;
    logic            in_exec;
    logic            restart;

    assign in_exec = (state == ST_EXEC);
    assign restart = (state == ST_HALT) && start;

    always_comb begin
        state_nxt = state;
        pc_sel    = PCSEL_HOLD;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  if (imem.imem_ack) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt = ST_FETCH;
                case (dec_op_code)
                    OP_JMP:  pc_sel = PCSEL_TGT;
                    OP_BRZ:  pc_sel = zflag ? PCSEL_TGT : PCSEL_INC;
                    OP_HALT: state_nxt = ST_HALT;
                    default: pc_sel = PCSEL_INC;
                endcase
            end
            ST_HALT: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    pc_sel    = PCSEL_RST;
                end
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    nibble_pc_next #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .sel    (pc_sel),
        .pc     (pc),
        .target (dec_y),
        .pc_nxt (pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            ir    <= '0;
            zflag <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            // Acks outside FETCH are stray strobes and must not touch the IR.
            if ((state == ST_FETCH) && imem.imem_ack) ir <= imem.imem_data;
            if (in_exec && is_alu_op(dec_op_code)) begin
                zflag <= alu_zero;
            end else if (restart) begin
                zflag <= 1'b0;
            end
        end
    end

`ifdef NIBBLE_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            retired_cnt <= '0;
        end else if (in_exec && (dec_op_code != OP_HALT)) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`endif

    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign busy           = (state == ST_FETCH) || (state == ST_DECODE) || in_exec;
    assign halted         = (state == ST_HALT);
    assign alu_src_imm    = in_exec && (dec_op_code == OP_LDI);
    assign rf_we          = in_exec && ((dec_op_code == OP_LDI) || is_alu_op(dec_op_code));
    assign alu_op         = (in_exec && is_alu_op(dec_op_code)) ? alu_of_op(dec_op_code) : ALU_ADD;

endmodule
